// File: rtl/fir.sv
// ============================================================================
//  Module      : fir
//  Description : 4-tap direct-form FIR filter, signed samples and live
//                coefficients, registered full-precision output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir #(
    parameter int DW = 17,
    parameter int OW = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] c0,
    input  logic signed [DW-1:0] c1,
    input  logic signed [DW-1:0] c2,
    input  logic signed [DW-1:0] c3,
    output logic signed [OW-1:0] y_out
);

    localparam int PW = 2 * DW;

    logic signed [DW-1:0] d1;
    logic signed [DW-1:0] d2;
    logic signed [DW-1:0] d3;

    logic signed [PW-1:0] x0_ext;
    logic signed [PW-1:0] x1_ext;
    logic signed [PW-1:0] x2_ext;
    logic signed [PW-1:0] x3_ext;
    logic signed [PW-1:0] c0_ext;
    logic signed [PW-1:0] c1_ext;
    logic signed [PW-1:0] c2_ext;
    logic signed [PW-1:0] c3_ext;

    logic signed [PW-1:0] p0;
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic signed [PW-1:0] p3;

    logic signed [OW-1:0] sum_next;

    // Operands widened to the product width so the multiply is exact.
    always_comb begin
        x0_ext = {{DW{x_in[DW-1]}}, x_in};
        x1_ext = {{DW{d1[DW-1]}},   d1};
        x2_ext = {{DW{d2[DW-1]}},   d2};
        x3_ext = {{DW{d3[DW-1]}},   d3};
        c0_ext = {{DW{c0[DW-1]}},   c0};
        c1_ext = {{DW{c1[DW-1]}},   c1};
        c2_ext = {{DW{c2[DW-1]}},   c2};
        c3_ext = {{DW{c3[DW-1]}},   c3};
    end

    always_comb begin
        p0 = c0_ext * x0_ext;
        p1 = c1_ext * x1_ext;
        p2 = c2_ext * x2_ext;
        p3 = c3_ext * x3_ext;
    end

    always_comb begin
        sum_next = {{(OW-PW){p0[PW-1]}}, p0}
                 + {{(OW-PW){p1[PW-1]}}, p1}
                 + {{(OW-PW){p2[PW-1]}}, p2}
                 + {{(OW-PW){p3[PW-1]}}, p3};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            d1 <= x_in;
            d2 <= d1;
            d3 <= d2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_out <= '0;
        end else begin
            y_out <= sum_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir.sv
// ============================================================================
//  Module      : tb_fir
//  Description : Self-checking bench for fir against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir;

    logic               clk;
    logic               reset;
    logic signed [16:0] x_in;
    logic signed [16:0] c0, c1, c2, c3;
    logic signed [35:0] y_out;

    int n_checks;
    int n_pass;

    // Model: newest sample first, at most four entries.
    longint hist[$];
    longint coef[4];

    fir dut (
        .clk   (clk),
        .reset (reset),
        .x_in  (x_in),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .y_out (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic signed [35:0] obs,
                             input logic signed [35:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic set_coefs(input int a, input int b, input int c, input int d);
        c0 = 17'(a); c1 = 17'(b); c2 = 17'(c); c3 = 17'(d);
        coef[0] = a; coef[1] = b; coef[2] = c; coef[3] = d;
    endtask

    function automatic longint model_y();
        longint s = 0;
        for (int i = 0; i < hist.size(); i++) s += coef[i] * hist[i];
        return s;
    endfunction

    // Drive one sample, clock it, compare against the model; returns expectation.
    task automatic step(input int x, input string tag, output longint exp);
        x_in = 17'(x);
        hist.push_front(longint'(x));
        if (hist.size() > 4) void'(hist.pop_back());
        exp = model_y();
        @(posedge clk);
        #1;
        check_val(tag, y_out, 36'(exp));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        hist.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        longint e;
        longint prev;
        int     seq[7];
        longint ref_seq[11];

        n_checks = 0;
        n_pass   = 0;
        seq      = '{3, 2, 1, 0, 1, 2, 3};
        ref_seq  = '{0, 3, 8, 14, 8, 4, 4, 10, 12, 9, 0};

        // Reset held: outputs stay zero even with live input.
        reset = 1'b1;
        x_in  = 17'sd5;
        set_coefs(1, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("reset_hold", y_out, 36'sd0);
        end
        x_in  = '0;
        reset = 1'b0;
        hist.delete();
        for (int i = 0; i < 3; i++) step(0, "post_reset_zero", e);

        // Impulse/step sequence against the fixed expected table.
        set_coefs(0, 1, 2, 3);
        for (int i = 0; i < 11; i++) begin
            step((i < 7) ? seq[i] : 0, "impulse_seq", e);
            check_val("impulse_table", y_out, 36'(ref_seq[i]));
        end

        // Negative samples.
        set_coefs(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(-1, "negative", e);
            check_val("negative_table", y_out, 36'(-((i < 4) ? i + 1 : 4)));
        end

        // Extreme magnitudes.
        set_coefs(-65536, -65536, -65536, -65536);
        for (int i = 0; i < 5; i++) step(-65536, "extreme_pos", e);
        check_val("extreme_pos_final", y_out, 36'sd17179869184);
        for (int i = 0; i < 5; i++) step(65535, "extreme_neg", e);
        check_val("extreme_neg_final", y_out, 36'(-64'sd4 * 65536 * 65535));

        // Asynchronous reset mid-stream.
        pulse_reset();
        set_coefs(0, 1, 2, 3);
        for (int i = 0; i < 4; i++) step(seq[i], "pre_async", e);
        #2;
        reset = 1'b1;
        hist.delete();
        #1;
        check_val("async_reset_y", y_out, 36'sd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step((i < 7) ? seq[i] : 0, "restart_seq", e);
            check_val("restart_table", y_out, 36'(ref_seq[i]));
        end

        // Live coefficient change.
        set_coefs(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(2, "coef_steady", e);
        prev = e;
        set_coefs(1, 1, 1, 5);
        step(2, "coef_change", e);
        check_val("coef_change_delta", y_out, 36'(prev + 10));

        // Randomized stream with occasional coefficient updates.
        for (int i = 0; i < 300; i++) begin
            if (i % 17 == 0)
                set_coefs(int'($urandom_range(0, 131071)) - 65536,
                          int'($urandom_range(0, 131071)) - 65536,
                          int'($urandom_range(0, 131071)) - 65536,
                          int'($urandom_range(0, 131071)) - 65536);
            step(int'($urandom_range(0, 131071)) - 65536, "random", e);
        end

        // Flush: zero input clears the output after four edges.
        for (int i = 0; i < 4; i++) step(0, "flush", e);
        check_val("flush_zero", y_out, 36'sd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
